// File: rtl/uart_boot_loader_if.sv
// Byte-stream, response and SRAM write-port signals of the UART boot loader.
// The loader drives the master side; the UART and SRAM glue drive the slave side.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_enable;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_enable;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_ack,
    output rx_ready, rx_enable, tx_data, tx_valid, tx_enable,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_ack,
    input  rx_ready, rx_enable, tx_data, tx_valid, tx_enable,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Frame loader: A5, word count, little-endian data words, 8-bit sum; writes SRAM
// from word 0, holds the core in reset until a good frame, answers ACK/NAK.
module uart_boot_loader #(
  parameter int         ADDR_W      = 5,
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_boot_loader_if.master bus,
  output logic               cpu_rst,
  output logic               load_done,
  output logic               load_err
);
  localparam int CNT_W     = ADDR_W + 1;
  localparam int MAX_WORDS = 1 << ADDR_W;
  localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, RESP, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] idx;
  logic [1:0]       bcnt;
  logic [7:0]       csum;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      wdata;
  logic [7:0]       tx_byte;
  logic             resp_ok;
  logic             consume;
  logic             counting;
  logic             timed_out;

  assign bus.rx_ready = (state == IDLE) || (state == LEN) || (state == DATA) || (state == CSUM);
  assign consume      = bus.rx_valid && bus.rx_ready;
  assign counting     = (state == LEN) || (state == DATA) || (state == CSUM);
  assign timed_out    = counting && !consume && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Everything the outside world sees is decoded from registered state
  assign bus.rx_enable = (state != RUN);
  assign bus.tx_enable = 1'b1;
  assign bus.tx_valid  = (state == RESP);
  assign bus.tx_data   = tx_byte;
  assign bus.mem_cs    = (state == WRITE);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = idx[ADDR_W-1:0];
  assign bus.mem_wdata = wdata;
  assign cpu_rst       = (state != RUN);
  assign load_done     = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      idx      <= '0;
      bcnt     <= '0;
      csum     <= '0;
      tmo_cnt  <= '0;
      wdata    <= '0;
      tx_byte  <= '0;
      resp_ok  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      // Inter-byte timer: frozen outside LEN/DATA/CSUM, restarted by every byte
      if (consume)
        tmo_cnt <= '0;
      else if (counting)
        tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (consume && bus.rx_data == HDR_BYTE)
            state <= LEN;
        end
        LEN: begin
          if (consume) begin
            idx  <= '0;
            bcnt <= '0;
            csum <= '0;
            if (int'(bus.rx_data) > MAX_WORDS) begin
              load_err <= 1'b1;
              tx_byte  <= NAK_BYTE;
              resp_ok  <= 1'b0;
              state    <= RESP;
            end else begin
              len   <= CNT_W'(bus.rx_data);
              state <= (bus.rx_data == 8'd0) ? CSUM : DATA;
            end
          end
        end
        DATA: begin
          if (consume) begin
            wdata[{bcnt, 3'b000} +: 8] <= bus.rx_data;
            csum <= csum + bus.rx_data;
            bcnt <= bcnt + 1'b1;
            if (bcnt == 2'd3)
              state <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            idx   <= idx + 1'b1;
            state <= (CNT_W'(idx + 1'b1) == len) ? CSUM : DATA;
          end
        end
        CSUM: begin
          if (consume) begin
            state <= RESP;
            if (bus.rx_data == csum) begin
              tx_byte <= ACK_BYTE;
              resp_ok <= 1'b1;
            end else begin
              load_err <= 1'b1;
              tx_byte  <= NAK_BYTE;
              resp_ok  <= 1'b0;
            end
          end
        end
        RESP: begin
          if (bus.tx_ready)
            state <= resp_ok ? RUN : IDLE;
        end
        RUN: state <= RUN;
        default: state <= IDLE;
      endcase

      // A stalled frame is rejected exactly like a bad one
      if (timed_out) begin
        load_err <= 1'b1;
        tx_byte  <= NAK_BYTE;
        resp_ok  <= 1'b0;
        tmo_cnt  <= '0;
        state    <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frame table plus timeout, slow-SRAM and
// reset-during-write sequences, with an SRAM responder and load_err pulse counter.
module tb_uart_boot_loader;
  localparam int ADDR_W = 5;
  localparam int TMO    = 40;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_rst, load_done, load_err;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_boot_loader #(
    .ADDR_W     (ADDR_W),
    .HDR_BYTE   (8'hA5),
    .ACK_BYTE   (8'h06),
    .NAK_BYTE   (8'h15),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_rst  (cpu_rst),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SRAM responder state, written only by the responder process
  int          ack_dly = 0;
  bit          ack_block = 1'b0;
  int          wr_cnt = 0;
  int          stable_bad = 0;
  int          wait_cnt = 0;
  logic [31:0] wr_data [0:255];
  logic [4:0]  wr_addr [0:255];
  int          err_pulses = 0;

  initial begin : mem_model
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_cs && rst_n && !ack_block) begin
        if (wait_cnt == 0) begin
          wr_addr[wr_cnt] = bus.mem_addr;
          wr_data[wr_cnt] = bus.mem_wdata;
          wr_cnt++;
        end else if (bus.mem_addr !== wr_addr[wr_cnt-1] || bus.mem_wdata !== wr_data[wr_cnt-1] ||
                     bus.rx_ready !== 1'b0) begin
          stable_bad++;
        end
        if (bus.mem_we !== 1'b1) stable_bad++;
        if (wait_cnt == ack_dly) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : err_monitor
    forever begin
      @(negedge clk);
      if (load_err === 1'b1) err_pulses++;
    end
  end

  typedef struct {
    logic [95:0] fr;      // frame bytes, first byte in [95:88]
    int          nb;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  resp;
    logic        cpu_rst;
    logic        done;
    int          errs;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: byte %h not taken within %0d cycles", b, n);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [95:0] fr, input int nb);
    for (int i = 0; i < nb; i++) send_byte(fr[95-8*i -: 8]);
  endtask

  task automatic get_resp(output logic [7:0] b);
    int n = 0;
    b = 8'h00;
    while (bus.tx_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_wait: tx_valid %b after %0d cycles, want 1", bus.tx_valid, n);
    end else begin
      b = bus.tx_data;
      repeat (2) @(negedge clk);
      chk("tx_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, b});
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
      chk("tx_release", {31'd0, bus.tx_valid}, 32'd0);
    end
  endtask

  logic [7:0] rb;
  int wr_base, err_base, stb_base;

  initial begin
    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;

    vecs[0] = '{96'hA5017856341214_0000000000, 7, 1, 32'h12345678, 32'h0, 8'h06, 1'b0, 1'b1, 0};
    vecs[1] = '{96'hA50201020304050607082500, 11, 2, 32'h04030201, 32'h08070605, 8'h15, 1'b1, 1'b0, 1};
    vecs[2] = '{96'h00FFA50000_00000000000000, 5, 0, 32'h0, 32'h0, 8'h06, 1'b0, 1'b1, 0};
    vecs[3] = '{96'hA521_00000000000000000000, 2, 0, 32'h0, 32'h0, 8'h15, 1'b1, 1'b0, 1};
    vecs[4] = '{96'hA50201020304050607082400, 11, 2, 32'h04030201, 32'h08070605, 8'h06, 1'b0, 1'b1, 0};
    vecs[5] = '{96'hA50001_000000000000000000, 3, 0, 32'h0, 32'h0, 8'h15, 1'b1, 1'b0, 1};

    // Reset state
    do_reset();
    chk("rst_cpu_rst",   {31'd0, cpu_rst}, 32'd1);
    chk("rst_rx_enable", {31'd0, bus.rx_enable}, 32'd1);
    chk("rst_tx_enable", {31'd0, bus.tx_enable}, 32'd1);
    chk("rst_tx",        {23'd0, bus.tx_valid, bus.tx_data}, 32'd0);
    chk("rst_mem_ctl",   {30'd0, bus.mem_cs, bus.mem_we}, 32'd0);
    chk("rst_mem_addr",  {27'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_status",    {30'd0, load_done, load_err}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      wr_base  = wr_cnt;
      err_base = err_pulses;
      send_frame(vecs[v].fr, vecs[v].nb);
      get_resp(rb);
      chk($sformatf("v%0d_resp", v), {24'd0, rb}, {24'd0, vecs[v].resp});
      chk($sformatf("v%0d_nwr", v), wr_cnt - wr_base, vecs[v].nwr);
      if (vecs[v].nwr > 0) begin
        chk($sformatf("v%0d_w0", v), wr_data[wr_base], vecs[v].w0);
        chk($sformatf("v%0d_a0", v), {27'd0, wr_addr[wr_base]}, 32'd0);
      end
      if (vecs[v].nwr > 1) begin
        chk($sformatf("v%0d_w1", v), wr_data[wr_base+1], vecs[v].w1);
        chk($sformatf("v%0d_a1", v), {27'd0, wr_addr[wr_base+1]}, 32'd1);
      end
      chk($sformatf("v%0d_cpu_rst", v), {31'd0, cpu_rst}, {31'd0, vecs[v].cpu_rst});
      chk($sformatf("v%0d_done", v), {31'd0, load_done}, {31'd0, vecs[v].done});
      chk($sformatf("v%0d_rx_en", v), {31'd0, bus.rx_enable}, {31'd0, !vecs[v].done});
      chk($sformatf("v%0d_errs", v), err_pulses - err_base, vecs[v].errs);
    end

    // Bad frame, then a good frame without reset
    do_reset();
    wr_base = wr_cnt;
    send_frame(vecs[1].fr, vecs[1].nb);
    get_resp(rb);
    chk("retry_nak", {24'd0, rb}, 32'h15);
    chk("retry_idle_rdy", {31'd0, bus.rx_ready}, 32'd1);
    send_frame(vecs[0].fr, vecs[0].nb);
    get_resp(rb);
    chk("retry_ack", {24'd0, rb}, 32'h06);
    chk("retry_w", wr_data[wr_base+2], 32'h12345678);
    chk("retry_a", {27'd0, wr_addr[wr_base+2]}, 32'd0);
    chk("retry_done", {30'd0, load_done, cpu_rst}, 32'd2);

    // No timeout in IDLE; slow SRAM ack; stall after two data bytes
    do_reset();
    err_base = err_pulses;
    repeat (TMO + 10) @(negedge clk);
    chk("idle_no_tmo", {31'd0, bus.tx_valid}, 32'd0);
    chk("idle_no_err", err_pulses - err_base, 32'd0);
    ack_dly  = 5;
    wr_base  = wr_cnt;
    stb_base = stable_bad;
    send_frame(96'hA50211223344556600000000, 8);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_early", {31'd0, bus.tx_valid}, 32'd0);
    @(negedge clk);
    chk("tmo_edge", {31'd0, bus.tx_valid}, 32'd1);
    get_resp(rb);
    chk("tmo_nak", {24'd0, rb}, 32'h15);
    chk("tmo_err", err_pulses - err_base, 32'd1);
    chk("slow_nwr", wr_cnt - wr_base, 32'd1);
    chk("slow_w0", wr_data[wr_base], 32'h44332211);
    chk("slow_stable", stable_bad - stb_base, 32'd0);
    chk("tmo_idle", {30'd0, bus.rx_ready, cpu_rst}, 32'd3);
    ack_dly = 0;

    // Reset while a write is outstanding
    do_reset();
    ack_block = 1'b1;
    send_frame(96'hA501AABBCCDD000000000000, 6);
    chk("wr_cs_up", {30'd0, bus.mem_cs, bus.mem_we}, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("wr_rst_cs", {31'd0, bus.mem_cs}, 32'd0);
    chk("wr_rst_cpu", {31'd0, cpu_rst}, 32'd1);
    chk("wr_rst_idle", {31'd0, bus.rx_ready}, 32'd1);
    rst_n = 1'b1;
    ack_block = 1'b0;
    wr_base = wr_cnt;
    send_frame(vecs[0].fr, vecs[0].nb);
    get_resp(rb);
    chk("after_rst_ack", {24'd0, rb}, 32'h06);
    chk("after_rst_w", wr_data[wr_base], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
